// File: rtl/ram1_uart_ctrl_pkg.sv
// Shared types and constants for the RAM1/UART bus controller.
package ram1_uart_ctrl_pkg;

   localparam int unsigned DATA_BUS = 16;
   localparam int unsigned ADDR_BUS = 18;
   localparam int unsigned CNT_W    = 4;

   localparam logic [DATA_BUS-1:0] UART_DATA_ADDR_DEF = 16'hBF00;
   localparam logic [DATA_BUS-1:0] UART_STAT_ADDR_DEF = 16'hBF01;

   typedef enum logic [3:0] {
      StIdle,
      StRamRd,
      StRamWrSu,
      StRamWrP,
      StRamWrH,
      StUartRd,
      StUartWrSu,
      StUartWrP,
      StUartWrH,
      StStatRd,
      StDone
   } state_e;

   // The counter runs from cycles-1 down to 0, so a value of 1 gives a single-cycle strobe.
   function automatic logic [CNT_W-1:0] cnt_load(input int unsigned cycles);
      return CNT_W'(cycles - 1);
   endfunction

endpackage

// File: rtl/ram1_uart_ctrl_bus_wait_cnt.sv
// Loadable 4-bit down-counter with zero flag, shared by all timed bus states.
module ram1_uart_ctrl_bus_wait_cnt
   import ram1_uart_ctrl_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] load_val,
   input  logic             dec,
   output logic             zero
);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (dec && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign zero = (cnt_q == '0);

endmodule

// File: rtl/ram1_uart_ctrl.sv
// Serialises single-word MEM-stage accesses onto the shared RAM1/UART data bus.
module ram1_uart_ctrl
   import ram1_uart_ctrl_pkg::*;
#(
   parameter int unsigned          RD_WAIT        = 2,
   parameter int unsigned          WR_PULSE       = 1,
   parameter logic [DATA_BUS-1:0]  UART_DATA_ADDR = UART_DATA_ADDR_DEF,
   parameter logic [DATA_BUS-1:0]  UART_STAT_ADDR = UART_STAT_ADDR_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req,
   input  logic                req_we,
   input  logic [DATA_BUS-1:0] req_addr,
   input  logic [DATA_BUS-1:0] req_wdata,
   output logic                ack,
   output logic [DATA_BUS-1:0] rdata,
   output logic                busy,
   inout  wire  [DATA_BUS-1:0] ram1_data,
   output logic [ADDR_BUS-1:0] ram1_addr,
   output logic                ram1_en,
   output logic                ram1_oe,
   output logic                ram1_we,
   input  logic                tsre,
   input  logic                tbre,
   input  logic                data_ready,
   output logic                rdn,
   output logic                wrn
);

   state_e              state_q, state_d;
   logic [DATA_BUS-1:0] addr_q, addr_d;
   logic [DATA_BUS-1:0] wdata_q, wdata_d;
   logic [DATA_BUS-1:0] rdata_q, rdata_d;

   logic             cnt_load_en;
   logic [CNT_W-1:0] cnt_load_val;
   logic             cnt_dec;
   logic             cnt_zero;
   logic             bus_drive;

   ram1_uart_ctrl_bus_wait_cnt u_bus_wait_cnt (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load_en),
      .load_val (cnt_load_val),
      .dec      (cnt_dec),
      .zero     (cnt_zero)
   );

   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rdata_d      = rdata_q;
      cnt_load_en  = 1'b0;
      cnt_load_val = '0;
      cnt_dec      = 1'b0;

      case (state_q)
         StIdle: begin
            if (req) begin
               addr_d  = req_addr;
               wdata_d = req_wdata;
               // Decode on the live inputs; they are latched on this same edge.
               if (req_addr == UART_DATA_ADDR) begin
                  if (req_we) begin
                     state_d = StUartWrSu;
                  end else begin
                     state_d      = StUartRd;
                     cnt_load_en  = 1'b1;
                     cnt_load_val = cnt_load(RD_WAIT);
                  end
               end else if (req_addr == UART_STAT_ADDR) begin
                  state_d = req_we ? StDone : StStatRd;
               end else if (req_we) begin
                  state_d = StRamWrSu;
               end else begin
                  state_d      = StRamRd;
                  cnt_load_en  = 1'b1;
                  cnt_load_val = cnt_load(RD_WAIT);
               end
            end
         end
         StRamRd, StUartRd: begin
            if (cnt_zero) begin
               rdata_d = ram1_data;
               state_d = StDone;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StRamWrSu, StUartWrSu: begin
            cnt_load_en  = 1'b1;
            cnt_load_val = cnt_load(WR_PULSE);
            state_d      = (state_q == StRamWrSu) ? StRamWrP : StUartWrP;
         end
         StRamWrP, StUartWrP: begin
            if (cnt_zero) begin
               state_d = (state_q == StRamWrP) ? StRamWrH : StUartWrH;
            end else begin
               cnt_dec = 1'b1;
            end
         end
         StRamWrH, StUartWrH: begin
            state_d = StDone;
         end
         StStatRd: begin
            rdata_d = {{(DATA_BUS-2){1'b0}}, data_ready, tsre & tbre};
            state_d = StDone;
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Strobes decode straight from the state register so an async reset releases them at once.
   always_comb begin
      ram1_en   = 1'b1;
      ram1_oe   = 1'b1;
      ram1_we   = 1'b1;
      rdn       = 1'b1;
      wrn       = 1'b1;
      bus_drive = 1'b0;
      case (state_q)
         StRamRd: begin
            ram1_en = 1'b0;
            ram1_oe = 1'b0;
         end
         StRamWrSu, StRamWrH: begin
            ram1_en   = 1'b0;
            bus_drive = 1'b1;
         end
         StRamWrP: begin
            ram1_en   = 1'b0;
            ram1_we   = 1'b0;
            bus_drive = 1'b1;
         end
         StUartRd: begin
            rdn = 1'b0;
         end
         StUartWrSu, StUartWrH: begin
            bus_drive = 1'b1;
         end
         StUartWrP: begin
            wrn       = 1'b0;
            bus_drive = 1'b1;
         end
         default: begin
            bus_drive = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         rdata_q <= rdata_d;
      end
   end

   assign ram1_data = bus_drive ? wdata_q : {DATA_BUS{1'bz}};
   assign ram1_addr = {2'b00, addr_q};
   assign rdata     = rdata_q;
   assign ack       = (state_q == StDone);
   assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_ram1_uart_ctrl.sv
// Scoreboard bench for ram1_uart_ctrl: directed accesses, monitor checks ack latency and rdata.
module tb_ram1_uart_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, req_we;
   logic [15:0] req_addr, req_wdata;
   logic        ack, busy;
   logic [15:0] rdata;
   wire  [15:0] ram1_data;
   logic [17:0] ram1_addr;
   logic        ram1_en, ram1_oe, ram1_we;
   logic        tsre, tbre, data_ready;
   logic        rdn, wrn;

   logic [15:0] model_val;

   always #5 clk = ~clk;

   // Bus model: RAM answers on en&oe, UART answers on rdn.
   assign ram1_data = ((!ram1_oe && !ram1_en) || !rdn) ? model_val : 16'hzzzz;

   ram1_uart_ctrl #(
      .RD_WAIT        (2),
      .WR_PULSE       (1),
      .UART_DATA_ADDR (16'hBF00),
      .UART_STAT_ADDR (16'hBF01)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .req_we     (req_we),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .ack        (ack),
      .rdata      (rdata),
      .busy       (busy),
      .ram1_data  (ram1_data),
      .ram1_addr  (ram1_addr),
      .ram1_en    (ram1_en),
      .ram1_oe    (ram1_oe),
      .ram1_we    (ram1_we),
      .tsre       (tsre),
      .tbre       (tbre),
      .data_ready (data_ready),
      .rdn        (rdn),
      .wrn        (wrn)
   );

   typedef struct {
      logic [15:0] rdata;
      bit          chk_rdata;
      int unsigned acc;
      int unsigned lat;
      string       name;
   } exp_t;

   exp_t sb[$];

   int checks   = 0;
   int failures = 0;

   int unsigned edge_n = 0;
   always @(posedge clk) edge_n <= edge_n + 1;

   // Free-running observation counters, sampled on the falling edge.
   int          oe_lo = 0, we_lo = 0, rdn_lo = 0, wrn_lo = 0, contend = 0, ack_total = 0;
   int          idle_run = 0, last_gap = 0;
   logic        prev_wr = 1'b1;
   logic [15:0] prev_bus = '0, bus_before = '0, bus_after = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req_v);
      end
   endtask

   initial begin
      exp_t        e;
      int unsigned lat;
      forever begin
         @(negedge clk);
         if (!ram1_oe) oe_lo++;
         if (!ram1_we) we_lo++;
         if (!rdn) rdn_lo++;
         if (!wrn) wrn_lo++;
         if (!ram1_en && (!rdn || !wrn)) contend++;
         if (prev_wr && !(ram1_we && wrn)) bus_before = prev_bus;
         if (!prev_wr && (ram1_we && wrn)) bus_after = ram1_data;
         prev_wr  = ram1_we && wrn;
         prev_bus = ram1_data;
         if (!busy) begin
            idle_run++;
         end else begin
            if (idle_run != 0) last_gap = idle_run;
            idle_run = 0;
         end
         if (ack) begin
            ack_total++;
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_ack actual=ack required=no_ack at edge %0d", edge_n);
            end else begin
               e   = sb.pop_front();
               lat = edge_n - e.acc + 1;
               checks++;
               if (lat != e.lat) begin
                  failures++;
                  $display("FAIL %s_latency actual=%0d required=%0d", e.name, lat, e.lat);
               end
               if (e.chk_rdata) begin
                  checks++;
                  if (rdata !== e.rdata) begin
                     failures++;
                     $display("FAIL %s_rdata actual=%h required=%h", e.name, rdata, e.rdata);
                  end
               end
            end
         end
      end
   end

   task automatic do_req(input logic we, input logic [15:0] addr, input logic [15:0] wdata,
                         input logic [15:0] mval, input logic [15:0] exp_rd, input bit chk_rd,
                         input int unsigned lat, input bit scramble, input string name);
      exp_t e;
      bit   got = 1'b0;
      @(negedge clk);
      model_val   = mval;
      req         = 1'b1;
      req_we      = we;
      req_addr    = addr;
      req_wdata   = wdata;
      e.rdata     = exp_rd;
      e.chk_rdata = chk_rd;
      e.acc       = edge_n + 1;
      e.lat       = lat;
      e.name      = name;
      sb.push_back(e);
      if (scramble) begin
         @(negedge clk);
         req_addr  = 16'h1357;
         req_wdata = 16'hFFFF;
      end
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (ack) begin
            got = 1'b1;
            break;
         end
      end
      req = 1'b0;
      if (!got) begin
         checks++;
         failures++;
         $display("FAIL %s_timeout actual=no_ack required=ack", name);
      end
   endtask

   initial begin
      int s_oe, s_we, s_rdn, s_wrn, s_cont, s_ack;
      bit seen;
      rst = 1'b0; req = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
      tsre = 1'b0; tbre = 1'b0; data_ready = 1'b0; model_val = '0;
      repeat (3) @(negedge clk);
      chk("rst_ack", {31'b0, ack}, 32'd0);
      chk("rst_busy", {31'b0, busy}, 32'd0);
      chk("rst_rdata", {16'b0, rdata}, 32'h0);
      chk("rst_strobes", {27'b0, ram1_en, ram1_oe, ram1_we, rdn, wrn}, 32'h1F);
      chk("rst_addr", {14'b0, ram1_addr}, 32'h0);
      rst = 1'b1;

      s_oe = oe_lo; s_rdn = rdn_lo;
      do_req(1'b0, 16'h4000, 16'h0000, 16'h1234, 16'h1234, 1'b1, 3, 1'b0, "ram_rd");
      chk("ram_rd_oe_cycles", oe_lo - s_oe, 2);
      chk("ram_rd_rdn_cycles", rdn_lo - s_rdn, 0);
      chk("ram_rd_addr", {14'b0, ram1_addr}, 32'h04000);

      s_we = we_lo;
      do_req(1'b1, 16'h0010, 16'hBEEF, 16'h0000, 16'h0, 1'b0, 4, 1'b0, "ram_wr");
      chk("ram_wr_we_cycles", we_lo - s_we, 1);
      chk("ram_wr_bus_before", {16'b0, bus_before}, 32'hBEEF);
      chk("ram_wr_bus_after", {16'b0, bus_after}, 32'hBEEF);
      chk("ram_wr_addr", {14'b0, ram1_addr}, 32'h00010);

      s_we = we_lo; s_wrn = wrn_lo; s_cont = contend;
      do_req(1'b1, 16'hBF00, 16'h0041, 16'h0000, 16'h0, 1'b0, 4, 1'b1, "uart_wr");
      chk("uart_wr_wrn_cycles", wrn_lo - s_wrn, 1);
      chk("uart_wr_we_cycles", we_lo - s_we, 0);
      chk("uart_wr_contention", contend - s_cont, 0);
      chk("uart_wr_bus_before", {16'b0, bus_before}, 32'h0041);
      chk("uart_wr_bus_after", {16'b0, bus_after}, 32'h0041);

      s_rdn = rdn_lo; s_oe = oe_lo; s_cont = contend;
      do_req(1'b0, 16'hBF00, 16'h0000, 16'h005A, 16'h005A, 1'b1, 3, 1'b0, "uart_rd");
      chk("uart_rd_rdn_cycles", rdn_lo - s_rdn, 2);
      chk("uart_rd_oe_cycles", oe_lo - s_oe, 0);
      chk("uart_rd_contention", contend - s_cont, 0);

      data_ready = 1'b1; tsre = 1'b1; tbre = 1'b0;
      do_req(1'b0, 16'hBF01, 16'h0000, 16'h0000, 16'h0002, 1'b1, 2, 1'b0, "stat_rd_a");
      data_ready = 1'b0; tsre = 1'b1; tbre = 1'b1;
      do_req(1'b0, 16'hBF01, 16'h0000, 16'h0000, 16'h0001, 1'b1, 2, 1'b0, "stat_rd_b");

      s_oe = oe_lo; s_we = we_lo; s_rdn = rdn_lo; s_wrn = wrn_lo;
      do_req(1'b1, 16'hBF01, 16'h00FF, 16'h0000, 16'h0, 1'b0, 1, 1'b0, "stat_wr");
      chk("stat_wr_strobes", (oe_lo - s_oe) + (we_lo - s_we) + (rdn_lo - s_rdn) + (wrn_lo - s_wrn),
          0);
      chk("stat_wr_rdata_held", {16'b0, rdata}, 32'h0001);

      // Reset in the middle of the RAM write pulse.
      @(negedge clk);
      req = 1'b1; req_we = 1'b1; req_addr = 16'h0020; req_wdata = 16'h5555;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (!ram1_we) begin
            seen = 1'b1;
            break;
         end
      end
      chk("rstmid_reached_we", {31'b0, seen}, 32'd1);
      #2 rst = 1'b0;
      #1;
      chk("rstmid_strobes", {29'b0, ram1_we, ram1_en, ram1_oe}, 32'h7);
      chk("rstmid_busy", {31'b0, busy}, 32'd0);
      req = 1'b0;
      s_ack = ack_total;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rstmid_no_ack", ack_total - s_ack, 0);

      do_req(1'b0, 16'h0123, 16'h0000, 16'hA5C3, 16'hA5C3, 1'b1, 3, 1'b0, "ram_rd_after_rst");

      do_req(1'b0, 16'h0200, 16'h0000, 16'h1111, 16'h1111, 1'b1, 3, 1'b0, "b2b_first");
      do_req(1'b0, 16'h0201, 16'h0000, 16'h2222, 16'h2222, 1'b1, 3, 1'b0, "b2b_second");
      chk("b2b_idle_gap", last_gap, 1);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ram1_uart_ctrl.md
# ram1_uart_ctrl

Bus controller that owns the shared RAM1/UART data bus on the board and serialises data-memory accesses from the CPU MEM stage onto it. Each single-word request is decoded by address, either as a RAM1 access or as a UART data/status access. The controller then runs the matching strobe sequence (en/oe/we, or rdn/wrn) through a multi-cycle FSM and returns read data with a one-cycle acknowledge. It sits between the MEM stage and the RAM1/UART pins of `CPU`, clocked by the fast board clock.

## Interface
- RD_WAIT, default 2: cycles oe/rdn are held low before read data is sampled (1..15).
- WR_PULSE, default 1: cycles we/wrn are held low (1..15).
- UART_DATA_ADDR, default 16'hBF00: UART data register address.
- UART_STAT_ADDR, default 16'hBF01: UART status register address.
- clk  in  1  controller clock (50 MHz board clock); all state updates on the rising edge.
- rst  in  1  reset; one clock; reset is asynchronous and active-low.
- req  in  1  access request from MEM stage; held until ack.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  16  word address.
- req_wdata  in  16  write data.
- ack  out  1  one-cycle completion pulse.
- rdata  out  16  read data; valid while ack = 1 and held until the next completed read.
- busy  out  1  high whenever state is not IDLE.
- ram1_data  inout  16  shared RAM1/UART data bus.
- ram1_addr  out  18  RAM1 address, {2'b00, req_addr}.
- ram1_en, ram1_oe, ram1_we  out  1 each  active-low RAM1 strobes.
- tsre, tbre, data_ready  in  1 each  UART status inputs.
- rdn, wrn  out  1 each  active-low UART read/write strobes.

## Operation
- States: IDLE, RAM_RD, RAM_WR_SU, RAM_WR_P, RAM_WR_H, UART_RD, UART_WR_SU, UART_WR_P, UART_WR_H, STAT_RD, DONE.
- In IDLE with req = 1, the controller latches addr, we and wdata, then decodes:
  - addr == UART_DATA_ADDR → UART_RD or UART_WR_SU.
  - addr == UART_STAT_ADDR and read → STAT_RD.
  - addr == UART_STAT_ADDR and write → DONE directly; no bus activity.
  - Any other address → RAM_RD or RAM_WR_SU.
- RAM_RD: en = 0, oe = 0 for RD_WAIT cycles. ram1_data is sampled into rdata on the last cycle.
- RAM write: SU (1 cycle), P (WR_PULSE cycles), H (1 cycle).
  - en = 0 and the bus is driven with wdata through all three states.
  - we = 0 only in P.
- UART_RD: en = 1 (RAM1 disabled), rdn = 0 for RD_WAIT cycles. The bus is sampled into rdata on the last cycle.
- UART write: SU/P/H, as for RAM write, with en = 1 and wrn = 0 only in P.
- STAT_RD (1 cycle): rdata = {14'b0, data_ready, tsre & tbre}. No strobes asserted.
- DONE (1 cycle): ack = 1, then return to IDLE.
- Bus direction: ram1_data is driven only in write states and is high-Z otherwise. ram1_en = 1 whenever a UART strobe is active, so the two devices never contend.
- A shared 4-bit down-counter times the RD_WAIT/WR_PULSE states.
- UART writes do not check tbre/tsre. Software polls the status register.

## Timing
- Reset values: ack 0, rdata 0, busy 0, ram1_en/oe/we 1, rdn 1, wrn 1, ram1_addr 0, bus high-Z, state IDLE.
- Asserting rst mid-access releases all strobes and the bus asynchronously. The access is dropped and no ack is issued.
- Acceptance edge = the rising edge on which IDLE sees req = 1. busy rises after that edge.
- Cycles from acceptance edge to ack high:
  - Read (RAM or UART): RD_WAIT + 1.
  - Write: WR_PULSE + 3.
  - Status read: 2.
  - Status write: 1.
- The requester drops req in the cycle after ack. IDLE accepts a new request at the earliest on the edge after DONE, so back-to-back requests are spaced one idle cycle apart.
- If req is still high in IDLE after DONE, it is treated as a new request (requester bug; not masked).
- req_addr/req_we/req_wdata changes after acceptance are ignored (inputs are latched).
- Counter values RD_WAIT/WR_PULSE = 1 are legal (a single-cycle strobe).

## Structure
- `define.v` holds: the state encoding, UART_DATA_ADDR/UART_STAT_ADDR defaults, and the `DATA_BUS`/`ADDR_BUS` widths.
- One sub-module, `bus_wait_cnt`: loadable 4-bit down-counter with a zero flag, shared by all timed states.

## Test plan
- RAM read at 16'h4000, model returns 16'h1234, RD_WAIT = 2 → oe low exactly 2 cycles, ack 3 cycles after acceptance, rdata = 16'h1234, ram1_addr = 18'h04000.
- RAM write 16'hBEEF to 16'h0010, WR_PULSE = 1 → we low exactly 1 cycle, bus = 16'hBEEF one cycle before and one cycle after the we pulse, ack at +4.
- UART write 16'h0041 to 16'hBF00 → ram1_en held 1, wrn low 1 cycle, bus = 16'h0041; then UART read returns model byte 16'h005A with rdn low 2 cycles.
- Status read with data_ready = 1, tsre = 1, tbre = 0 → rdata = 16'h0002 and ack at +2; status write → ack at +1 with no strobe toggling.
- rst pulled low during RAM_WR_P → we, en and oe return to 1 immediately, bus goes high-Z, no ack; after release, a new read completes normally.
- Back-to-back reads with req re-asserted in the cycle after ack → second access accepted one cycle later, busy low for exactly one cycle between accesses.
